// File: rtl/lab2_pkg.sv
// Shared types and constants for the lab-2 display path: scanner states,
// the blank segment pattern and the hex segment encoding table.
package lab2_pkg;

    typedef enum logic [1:0] {
        BLANK1 = 2'd0,
        SHOW0  = 2'd1,
        BLANK0 = 2'd2,
        SHOW1  = 2'd3
    } scan_state_t;

    localparam logic [6:0] SEG_OFF = 7'h7F;

    // Active-low {g,f,e,d,c,b,a}; entry 0 sits in the least-significant slot.
    localparam logic [15:0][6:0] SEG_TABLE = {
        7'h0E,  // F
        7'h06,  // E
        7'h21,  // d
        7'h46,  // C
        7'h03,  // b
        7'h08,  // A
        7'h10,  // 9
        7'h00,  // 8
        7'h78,  // 7
        7'h02,  // 6
        7'h12,  // 5
        7'h19,  // 4
        7'h30,  // 3
        7'h24,  // 2
        7'h79,  // 1
        7'h40   // 0
    };

endpackage

// File: rtl/seven_seg_decoder.sv
// Combinational hex digit to active-low seven-segment pattern.
module seven_seg_decoder
    import lab2_pkg::*;
(
    input  logic [3:0] digit,
    output logic [6:0] seg
);

    assign seg = SEG_TABLE[digit];

endmodule

// File: rtl/display_scanner.sv
// Two-digit multiplexed seven-segment driver: synchronizes the switch
// operands, alternates digits per slot and blanks between digit changes.
module display_scanner
    import lab2_pkg::*;
#(
    parameter int REFRESH_DIV  = 24000,
    parameter int BLANK_CYCLES = 480
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [3:0] s1,
    input  logic [3:0] s2,
    output logic [6:0] seg,
    output logic       an0,
    output logic       an1
);

    localparam int CW = $clog2(REFRESH_DIV);
    localparam logic [CW-1:0] BLANK_LOAD = CW'(BLANK_CYCLES - 1);
    localparam logic [CW-1:0] SHOW_LOAD  = CW'(REFRESH_DIV - BLANK_CYCLES - 1);

    generate
        if (BLANK_CYCLES < 1 || BLANK_CYCLES >= REFRESH_DIV) begin : g_bad_params
            $error("display_scanner: BLANK_CYCLES must satisfy 1 <= BLANK_CYCLES < REFRESH_DIV");
        end
    endgenerate

    logic [3:0]  s1_meta_reg, s1_sync_reg;
    logic [3:0]  s2_meta_reg, s2_sync_reg;

    scan_state_t state_reg, state_next;
    logic [CW-1:0] cnt_reg, cnt_next;
    logic [3:0]  digit_reg, digit_next;
    logic [6:0]  seg_reg, seg_next;
    logic        an0_reg, an0_next;
    logic        an1_reg, an1_next;
    logic [6:0]  dec_seg;

    // The decoder looks at the value about to be held so the pattern is
    // registered on the same edge that enters the SHOW state.
    seven_seg_decoder u_decoder (
        .digit (digit_next),
        .seg   (dec_seg)
    );

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg - 1'b1;
        digit_next = digit_reg;
        if (cnt_reg == '0) begin
            case (state_reg)
                BLANK1: begin
                    state_next = SHOW0;
                    cnt_next   = SHOW_LOAD;
                    digit_next = s1_sync_reg;
                end
                SHOW0: begin
                    state_next = BLANK0;
                    cnt_next   = BLANK_LOAD;
                end
                BLANK0: begin
                    state_next = SHOW1;
                    cnt_next   = SHOW_LOAD;
                    digit_next = s2_sync_reg;
                end
                SHOW1: begin
                    state_next = BLANK1;
                    cnt_next   = BLANK_LOAD;
                end
                default: begin
                    state_next = BLANK1;
                    cnt_next   = BLANK_LOAD;
                end
            endcase
        end
    end

    always_comb begin
        seg_next = SEG_OFF;
        an0_next = 1'b1;
        an1_next = 1'b1;
        case (state_next)
            SHOW0: begin
                seg_next = dec_seg;
                an0_next = 1'b0;
            end
            SHOW1: begin
                seg_next = dec_seg;
                an1_next = 1'b0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_meta_reg <= '0;
            s1_sync_reg <= '0;
            s2_meta_reg <= '0;
            s2_sync_reg <= '0;
            state_reg   <= BLANK1;
            cnt_reg     <= BLANK_LOAD;
            digit_reg   <= '0;
            seg_reg     <= SEG_OFF;
            an0_reg     <= 1'b1;
            an1_reg     <= 1'b1;
        end else begin
            s1_meta_reg <= s1;
            s1_sync_reg <= s1_meta_reg;
            s2_meta_reg <= s2;
            s2_sync_reg <= s2_meta_reg;
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            digit_reg   <= digit_next;
            seg_reg     <= seg_next;
            an0_reg     <= an0_next;
            an1_reg     <= an1_next;
        end
    end

    assign seg = seg_reg;
    assign an0 = an0_reg;
    assign an1 = an1_reg;

endmodule

// File: tb/tb_display_scanner.sv
// Scoreboard bench for display_scanner with an 8-cycle slot and 2-cycle blank:
// stimulus queues per-cycle expected pins, a negedge monitor pops and compares.
module tb_display_scanner;

    localparam int RD = 8;
    localparam int BC = 2;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [3:0] s1 = 4'h0;
    logic [3:0] s2 = 4'h0;
    logic [6:0] seg;
    logic       an0;
    logic       an1;

    display_scanner #(
        .REFRESH_DIV  (RD),
        .BLANK_CYCLES (BC)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .s1      (s1),
        .s2      (s2),
        .seg     (seg),
        .an0     (an0),
        .an1     (an1)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [8:0] val;
        string      name;
    } exp_t;

    exp_t exp_q[$];
    int   nvec  = 0;
    int   nfail = 0;

    // Hand-written active-low {g,f,e,d,c,b,a} patterns for 0..F.
    logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    task automatic check(input string name, input logic [8:0] act, input logic [8:0] req);
        nvec++;
        if (act !== req) begin
            nfail++;
            $display("FAIL %s: actual {seg,an0,an1}=%h required=%h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: one queued expectation per cycle plus the always-on invariants.
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check(e.name, {seg, an0, an1}, e.val);
        end
        check("anode_excl", {8'b0, an0 | an1}, 9'd1);
        if (an0 && an1)
            check("blank_seg", {2'b0, seg}, {2'b0, 7'h7F});
    end

    // Queue the expectation for the next sample point, then advance one cycle.
    task automatic push_cycle(input string name, input logic [6:0] s, input logic a0, input logic a1);
        exp_t e;
        e.val  = {s, a0, a1};
        e.name = name;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic frame(input string tag, input logic [6:0] e0, input logic [6:0] e1,
                         input int chg_at, input logic [3:0] n1, input logic [3:0] n2,
                         input int ncyc);
        for (int c = 0; c < ncyc; c++) begin
            if (c == chg_at) begin
                s1 = n1;
                s2 = n2;
            end
            if (c < 2 || (c >= 8 && c < 10))
                push_cycle($sformatf("%s_c%0d_blank", tag, c), 7'h7F, 1'b1, 1'b1);
            else if (c < 8)
                push_cycle($sformatf("%s_c%0d_show0", tag, c), e0, 1'b0, 1'b1);
            else
                push_cycle($sformatf("%s_c%0d_show1", tag, c), e1, 1'b1, 1'b0);
        end
        $display("frame %s: s1=%h s2=%h expect show0=%h show1=%h", tag, s1, s2, e0, e1);
    endtask

    initial begin
        reset_n = 1'b0;
        s1 = 4'h3;
        s2 = 4'h0;
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++)
            push_cycle("reset_hold", 7'h7F, 1'b1, 1'b1);
        s1 = 4'h0;
        s2 = 4'h1;
        for (int i = 0; i < 2; i++)
            push_cycle("reset_hold", 7'h7F, 1'b1, 1'b1);
        reset_n = 1'b1;

        frame("first0", 7'h40, 7'h79, -1, 4'h0, 4'h1, 16);
        frame("first1", 7'h40, 7'h79, -1, 4'h0, 4'h1, 16);
        // s1 moves one cycle before SHOW0 entry: too late for this frame.
        frame("race", 7'h40, 7'h79, 0, 4'h8, 4'h1, 16);
        frame("midslot", 7'h00, 7'h79, 4, 4'hA, 4'h1, 16);
        frame("after", 7'h08, 7'h79, -1, 4'hA, 4'h1, 16);

        for (int v = 0; v < 16; v++)
            frame($sformatf("dec%0h", v), 7'h08, seg_tab[v], 0, 4'hA, 4'(v), 16);

        for (int i = 0; i < 10000; i++) begin
            s1 = 4'($urandom_range(0, 15));
            s2 = 4'($urandom_range(0, 15));
            @(posedge clk);
            #1;
        end
        $display("random phase: 10000 cycles of switch activity");

        reset_n = 1'b0;
        s1 = 4'h0;
        s2 = 4'h1;
        for (int i = 0; i < 2; i++)
            push_cycle("reset2_hold", 7'h7F, 1'b1, 1'b1);
        reset_n = 1'b1;
        frame("pre_reset", 7'h40, 7'h79, -1, 4'h0, 4'h1, 12);
        #2;
        check("show1_before_reset", {seg, an0, an1}, {7'h79, 1'b1, 1'b0});
        reset_n = 1'b0;
        #1;
        check("async_reset", {seg, an0, an1}, {7'h7F, 1'b1, 1'b1});
        $display("async reset mid-SHOW1: seg=%h an0=%b an1=%b", seg, an0, an1);
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++)
            push_cycle("reset3_hold", 7'h7F, 1'b1, 1'b1);
        reset_n = 1'b1;
        frame("restart0", 7'h40, 7'h79, -1, 4'h0, 4'h1, 16);
        frame("restart1", 7'h40, 7'h79, -1, 4'h0, 4'h1, 16);

        for (int i = 0; i < 4 && exp_q.size() > 0; i++)
            @(negedge clk);
        #1;
        check("queue_drain", 9'(exp_q.size()), 9'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule

// File: doc/display_scanner.md
# display_scanner

Time-multiplexed driver for the dual common-anode seven-segment display. Consumes the two 4-bit switch operands as raw asynchronous inputs and synchronizes them. Alternates between the two digits at a programmable slot rate and inserts a blanking gap at every digit change to suppress ghosting. Sits between the switch inputs and the display pins, alongside the combinational sum-to-LED path in the lab top level.

## Interface
- `REFRESH_DIV`, default 24000: clock cycles per digit slot. At 48 MHz HSOSC this gives 2 kHz slots and 1 kHz per digit.
- `BLANK_CYCLES`, default 480: cycles of each slot spent fully blanked. Legal range is 1 ≤ `BLANK_CYCLES` < `REFRESH_DIV`; elaboration fails otherwise.
- `clk` in 1: system clock. One clock domain; reset is asynchronous and active-low.
- `reset_n` in 1: asynchronous active-low reset.
- `s1` in 4: left-digit value (DIP switches), asynchronous to `clk`.
- `s2` in 4: right-digit value (DIP switches), asynchronous to `clk`.
- `seg` out 7: segment cathodes, active-low. Bit order {g,f,e,d,c,b,a}.
- `an0` out 1: digit-0 (s1) anode enable, active-low (PNP drive).
- `an1` out 1: digit-1 (s2) anode enable, active-low.

## Operation
- **Input synchronization:** `s1` and `s2` each pass through a 2-flop synchronizer (8 bits total).
- **States:** BLANK1 → SHOW0 → BLANK0 → SHOW1 → BLANK1, cycling forever.
- **State durations:** BLANK states last `BLANK_CYCLES` cycles; SHOW states last `REFRESH_DIV` − `BLANK_CYCLES` cycles.
- **Slot counter:** one down-counter of width $clog2(`REFRESH_DIV`). It is reloaded on every state transition; the transition fires when the count reaches 0.
- **Digit capture:**
  - On the transition into SHOW0, the synchronized s1 is captured into the digit register.
  - On the transition into SHOW1, the synchronized s2 is captured.
  - The displayed value is constant for the whole SHOW state, even if the switches move mid-slot.
- **Decoding:** the digit register is decoded as hex 0–F.
  - Encodings (active-low): 0 = 7'h40, 1 = 7'h79, 8 = 7'h00, A = 7'h08, F = 7'h0E.
- **Outputs per state:**
  - BLANK states: `seg` = 7'h7F, `an0` = `an1` = 1.
  - SHOW0: `an0` = 0, `an1` = 1, `seg` = decode(s1 capture).
  - SHOW1: `an0` = 1, `an1` = 0, `seg` = decode(s2 capture).
- **Invariant:** `an0` and `an1` are never both 0 in any cycle.
- **Reset values:** state BLANK1, counter = `BLANK_CYCLES` − 1, synchronizers 0, digit register 0, `seg` = 7'h7F, `an0` = `an1` = 1.
- **Reset asserted mid-operation:** outputs go to reset values immediately (asynchronous), with no waiting for the slot to end.

## Timing
- **Registered outputs:** all outputs come from flops, so there are no combinational glitches on the pins. Output values change on the same edge that enters the new state.
- **Startup after reset release:** with edges numbered from the first rising edge after `reset_n` rises:
  - BLANK1 occupies cycles 0 to `BLANK_CYCLES` − 1.
  - SHOW0 begins at cycle `BLANK_CYCLES`.
- **Frame period:** 2·`REFRESH_DIV` cycles. Digit duty cycle is (`REFRESH_DIV` − `BLANK_CYCLES`) / (2·`REFRESH_DIV`).
- **Input-to-display latency:** 2 synchronizer cycles plus wait for the next matching SHOW entry. Worst case is 2 + 2·`REFRESH_DIV` cycles.
- **Capture race:** a switch change that lands in the same cycle as a SHOW entry is captured if it was already present at the synchronizer output on that edge. Otherwise it appears on the next frame.

## Structure
- **Package `lab2_pkg`:**
  - Scanner state enum `scan_state_t` {BLANK1, SHOW0, BLANK0, SHOW1}.
  - Constant `SEG_OFF` = 7'h7F.
  - Segment encoding table for 0–F.
- **Sub-module `seven_seg_decoder`:** purely combinational, 4-bit in to 7-bit active-low out. It is reused by later labs.
- **Register placement:** `display_scanner` owns the FSM, counter, synchronizers, and output registers. The decoder output is registered inside `display_scanner`.

## Test plan
Bench parameters: `REFRESH_DIV` = 8, `BLANK_CYCLES` = 2.

- **Reset:** hold `reset_n` = 0 with `s1` = 4'h3 → `seg` = 7'h7F, `an0` = `an1` = 1 throughout reset.
- **First frame after release:** `s1` = 4'h0, `s2` = 4'h1 held →
  - cycles 0–1 blank;
  - cycles 2–7 `an0` = 0, `seg` = 7'h40;
  - cycles 8–9 blank;
  - cycles 10–15 `an1` = 0, `seg` = 7'h79;
  - pattern repeats every 16 cycles.
- **Mid-slot switch change:** change `s1` from 4'h8 to 4'hA at cycle 4 → `seg` stays 7'h00 until SHOW0 ends, then shows 7'h08 in the next frame's SHOW0.
- **Mutual exclusion:** random `s1`/`s2` changes over 10,000 cycles → assertion that `an0` and `an1` are never both 0. Also, `seg` = 7'h7F whenever both anodes are 1.
- **Reset mid-SHOW1:** assert `reset_n` = 0 asynchronously (between clock edges) → `an1` rises and `seg` = 7'h7F before the next clock edge. After release the sequence restarts at BLANK1 exactly as in the first-frame scenario.
- **Exhaustive decode:** sweep `s2` through 0–F → each SHOW1 slot shows the package table entry. For example F → 7'h0E.
